// File: rtl/rr_switch_allocator_4port.sv
// Registered round-robin switch allocator for the 4-port (X1, X2, Y, LOCAL)
// mesh router. Each output runs an independent IDLE/GRANT FSM, holds a grant
// for up to MAX_HOLD flits and then releases it for one bubble cycle.
// Port code for dst and sw: 0 none, 1 X1, 2 X2, 3 Y, 4 LOCAL (5-7 = none).
// Optional build macro SA_FIXED_PRIO_EN: replaces the round-robin pointers with
// fixed priority X1 > X2 > Y > LOCAL (MAX_HOLD still forces release).
module rr_switch_allocator_4port #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] port_x1_dst,
  input  logic [2:0] port_x2_dst,
  input  logic [2:0] port_y_dst,
  input  logic [2:0] port_local_dst,
  input  logic       out_x1_busy,
  input  logic       out_x2_busy,
  input  logic       out_y_busy,
  input  logic       out_local_busy,
  output logic       port_x1_en,
  output logic       port_x2_en,
  output logic       port_y_en,
  output logic       port_local_en,
  output logic [2:0] out_x1_sw,
  output logic [2:0] out_x2_sw,
  output logic [2:0] out_y_sw,
  output logic [2:0] out_local_sw,
  output logic       out_x1_valid,
  output logic       out_x2_valid,
  output logic       out_y_valid,
  output logic       out_local_valid
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Index 0..3 = X1, X2, Y, LOCAL for both inputs and outputs.
  logic [2:0]       dst     [4];
  logic [3:0]       busy;
  logic [3:0]       req     [4];   // req[o][i]: input i targets output o
  logic [1:0]       win_idx [4];
  logic [3:0]       win_req;
  logic [3:0]       valid;
  logic [3:0]       en;

  logic             state_q [4];
  logic             state_d [4];
  logic [2:0]       sw_q    [4];
  logic [2:0]       sw_d    [4];
  logic [CNT_W-1:0] hold_q  [4];
  logic [CNT_W-1:0] hold_d  [4];
`ifndef SA_FIXED_PRIO_EN
  logic [1:0]       ptr_q   [4];
  logic [1:0]       ptr_d   [4];
`endif

  assign dst[0] = port_x1_dst;
  assign dst[1] = port_x2_dst;
  assign dst[2] = port_y_dst;
  assign dst[3] = port_local_dst;
  assign busy   = {out_local_busy, out_y_busy, out_x2_busy, out_x1_busy};

`ifdef SA_FIXED_PRIO_EN
  function automatic logic [1:0] arb_pick(input logic [3:0] r);
    logic [1:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && r[i]) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`else
  // First requester after the last winner; k=4 wraps back to ptr itself.
  function automatic logic [1:0] arb_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`endif

  // Request matrix and per-output view of the current winner.
  always_comb begin
    logic [2:0] sw_m1;
    sw_m1 = '0;
    for (int unsigned o = 0; o < 4; o++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        req[o][i] = (dst[i] == 3'(o + 1));
      end
      sw_m1      = sw_q[o] - 3'd1;
      win_idx[o] = sw_m1[1:0];
      win_req[o] = (state_q[o] == ST_GRANT) && req[o][win_idx[o]];
      valid[o]   = (state_q[o] == ST_GRANT) && !busy[o] && win_req[o];
    end
  end

  // Input pop enables: an input advances when any valid output selects it.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      en[i] = 1'b0;
      for (int unsigned o = 0; o < 4; o++) begin
        if (valid[o] && (sw_q[o] == 3'(i + 1))) en[i] = 1'b1;
      end
    end
  end

  // Per-output FSM next state: arbitrate in IDLE, hold/freeze/release in GRANT.
  always_comb begin
    logic [1:0] pick;
    pick = '0;
    for (int unsigned o = 0; o < 4; o++) begin
      state_d[o] = state_q[o];
      sw_d[o]    = sw_q[o];
      hold_d[o]  = hold_q[o];
`ifndef SA_FIXED_PRIO_EN
      ptr_d[o]   = ptr_q[o];
`endif
      case (state_q[o])
        ST_IDLE: begin
          if (!busy[o] && (|req[o])) begin
`ifdef SA_FIXED_PRIO_EN
            pick = arb_pick(req[o]);
`else
            pick = arb_pick(req[o], ptr_q[o]);
`endif
            state_d[o] = ST_GRANT;
            sw_d[o]    = {1'b0, pick} + 3'd1;
            hold_d[o]  = CNT_W'(1);
          end
        end
        default: begin
          if (!busy[o]) begin
            if (!win_req[o] || (hold_q[o] == CNT_W'(MAX_HOLD))) begin
              state_d[o] = ST_IDLE;
              sw_d[o]    = '0;
              hold_d[o]  = '0;
`ifndef SA_FIXED_PRIO_EN
              ptr_d[o]   = win_idx[o];
`endif
            end else begin
              hold_d[o] = hold_q[o] + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // FSM, select and hold registers; pointers reset to LOCAL so X1 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < 4; o++) begin
        state_q[o] <= ST_IDLE;
        sw_q[o]    <= '0;
        hold_q[o]  <= '0;
`ifndef SA_FIXED_PRIO_EN
        ptr_q[o]   <= 2'd3;
`endif
      end
    end else begin
      for (int unsigned o = 0; o < 4; o++) begin
        state_q[o] <= state_d[o];
        sw_q[o]    <= sw_d[o];
        hold_q[o]  <= hold_d[o];
`ifndef SA_FIXED_PRIO_EN
        ptr_q[o]   <= ptr_d[o];
`endif
      end
    end
  end

  assign out_x1_sw       = sw_q[0];
  assign out_x2_sw       = sw_q[1];
  assign out_y_sw        = sw_q[2];
  assign out_local_sw    = sw_q[3];
  assign out_x1_valid    = valid[0];
  assign out_x2_valid    = valid[1];
  assign out_y_valid     = valid[2];
  assign out_local_valid = valid[3];
  assign port_x1_en      = en[0];
  assign port_x2_en      = en[1];
  assign port_y_en       = en[2];
  assign port_local_en   = en[3];

endmodule

// File: tb/tb_rr_switch_allocator_4port.sv
// Bench for rr_switch_allocator_4port: an owner/count/last-winner model checked
// against the DUT every negative clock edge, plus directed literal checks.
module tb_rr_switch_allocator_4port;

  localparam int unsigned MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] x1_dst = '0, x2_dst = '0, y_dst = '0, local_dst = '0;
  logic       x1_busy = 1'b0, x2_busy = 1'b0, y_busy = 1'b0, local_busy = 1'b0;
  logic       x1_en, x2_en, y_en, local_en;
  logic [2:0] x1_sw, x2_sw, y_sw, local_sw;
  logic       x1_v, x2_v, y_v, local_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_switch_allocator_4port #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_x1_dst(x1_dst), .port_x2_dst(x2_dst), .port_y_dst(y_dst), .port_local_dst(local_dst),
    .out_x1_busy(x1_busy), .out_x2_busy(x2_busy), .out_y_busy(y_busy), .out_local_busy(local_busy),
    .port_x1_en(x1_en), .port_x2_en(x2_en), .port_y_en(y_en), .port_local_en(local_en),
    .out_x1_sw(x1_sw), .out_x2_sw(x2_sw), .out_y_sw(y_sw), .out_local_sw(local_sw),
    .out_x1_valid(x1_v), .out_x2_valid(x2_v), .out_y_valid(y_v), .out_local_valid(local_v)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_own: input index holding the output (-1 = free); m_cnt: flits granted so
  // far in this tenure; m_last: most recent owner (round-robin reference).
  int m_own  [4] = '{-1, -1, -1, -1};
  int m_cnt  [4] = '{0, 0, 0, 0};
  int m_last [4] = '{3, 3, 3, 3};

  function automatic int dst_of(input int i);
    case (i)
      0: return int'(x1_dst);
      1: return int'(x2_dst);
      2: return int'(y_dst);
      default: return int'(local_dst);
    endcase
  endfunction

  function automatic bit busy_of(input int o);
    case (o)
      0: return x1_busy;
      1: return x2_busy;
      2: return y_busy;
      default: return local_busy;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 4; o++) begin
        m_own[o]  <= -1;
        m_cnt[o]  <= 0;
        m_last[o] <= 3;
      end
    end else begin
      for (int o = 0; o < 4; o++) begin
        int own, cnt, last, cand;
        own = m_own[o]; cnt = m_cnt[o]; last = m_last[o];
        if (own < 0) begin
          if (!busy_of(o)) begin
            for (int k = 1; k <= 4; k++) begin
`ifdef SA_FIXED_PRIO_EN
              cand = k - 1;
`else
              cand = (last + k) % 4;
`endif
              if (own < 0 && dst_of(cand) == o + 1) begin
                own = cand;
                cnt = 1;
              end
            end
          end
        end else if (!busy_of(o)) begin
          if (dst_of(own) != o + 1 || cnt == int'(MAX_HOLD)) begin
            last = own;
            own  = -1;
            cnt  = 0;
          end else begin
            cnt = cnt + 1;
          end
        end
        m_own[o]  <= own;
        m_cnt[o]  <= cnt;
        m_last[o] <= last;
      end
    end
  end

  // Compare process: every negative edge, all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] ev, ee, av, ae;
    logic [2:0] asw [4];
    ev = '0; ee = '0;
    av  = {local_v, y_v, x2_v, x1_v};
    ae  = {local_en, y_en, x2_en, x1_en};
    asw = '{x1_sw, x2_sw, y_sw, local_sw};
    for (int o = 0; o < 4; o++) begin
      if (m_own[o] >= 0 && !busy_of(o) && dst_of(m_own[o]) == o + 1) begin
        ev[o] = 1'b1;
        ee[m_own[o]] = 1'b1;
      end
      chk($sformatf("model_sw[%0d]", o), 8'(asw[o]), 8'(m_own[o] + 1));
    end
    chk("model_valid", 8'(av), 8'(ev));
    chk("model_en", 8'(ae), 8'(ee));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] vvec();
    return {local_v, y_v, x2_v, x1_v};
  endfunction

  function automatic logic [3:0] evec();
    return {local_en, y_en, x2_en, x1_en};
  endfunction

  initial begin
    logic [2:0] code;
    int g, pos;
    // 1: reset, then idle for 10 cycles
    cyc(3);
    #1;
    chk("rst_valid", 8'(vvec()), 8'h0);
    chk("rst_en", 8'(evec()), 8'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc(1); #1;
      chk("idle_valid", 8'(vvec()), 8'h0);
      chk("idle_sw", 8'({x1_sw, x2_sw}), 8'h0);
    end

    // 2: X1 and Y both to Y output
    cyc(1); x1_dst = 3'd3; y_dst = 3'd3;
    for (int c = 1; c <= 18; c++) begin
      cyc(1);
      if (c == 18) begin x1_dst = '0; y_dst = '0; end
      #1;
      if (c <= 8) begin
        chk("t2_sw_x1", 8'(y_sw), 8'd1);
        chk("t2_en_x1", 8'(evec()), 8'b0001);
      end else if (c == 9) begin
        chk("t2_bubble", 8'(y_v), 8'd0);
      end else if (c <= 17) begin
        chk("t2_sw_y", 8'(y_sw), 8'd3);
        chk("t2_en_y", 8'(evec()), 8'b0100);
      end
    end
    cyc(2);

    // busy while IDLE: no grant until busy clears
    x1_dst = 3'd3; y_busy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      if (c == 2) y_busy = 1'b0;
      if (c == 4) x1_dst = '0;
      #1;
      if (c <= 2) chk("busy_idle_sw", 8'({y_v, y_sw}), 8'h0);
      if (c == 3) chk("busy_idle_grant", 8'({y_v, y_sw}), 8'h9);
    end
    cyc(2);

    // codes 5..7 never request
    x1_dst = 3'd5; x2_dst = 3'd6; y_dst = 3'd7;
    cyc(3); #1;
    chk("bad_code_valid", 8'(vvec()), 8'h0);
    x1_dst = '0; x2_dst = '0; y_dst = '0;
    cyc(2);

    // 3: LOCAL -> X2 with busy freeze in cycles 3..5
    local_dst = 3'd2;
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      if (c == 3) x2_busy = 1'b1;
      if (c == 6) x2_busy = 1'b0;
      if (c == 12) local_dst = '0;
      #1;
      if (c <= 11) chk("t3_sw", 8'(x2_sw), 8'd4);
      if ((c >= 3 && c <= 5) || c == 12) begin
        chk("t3_frozen_valid", 8'(x2_v), 8'd0);
        chk("t3_frozen_en", 8'(local_en), 8'd0);
      end else begin
        chk("t3_valid", 8'({x2_v, local_en}), 8'h3);
      end
    end
    cyc(2);

    // 4: four disjoint requests in one cycle
    x1_dst = 3'd3; x2_dst = 3'd4; y_dst = 3'd1; local_dst = 3'd2;
    cyc(1); #1;
    chk("t4_valid", 8'(vvec()), 8'hf);
    chk("t4_en", 8'(evec()), 8'hf);
    chk("t4_sw_x1", 8'(x1_sw), 8'd3);
    chk("t4_sw_x2", 8'(x2_sw), 8'd4);
    chk("t4_sw_y", 8'(y_sw), 8'd1);
    chk("t4_sw_local", 8'(local_sw), 8'd2);
    cyc(1);
    x1_dst = '0; x2_dst = '0; y_dst = '0; local_dst = '0;
    cyc(2);

    // reset to restore pointers, then 5: everyone to LOCAL
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    x1_dst = 3'd4; x2_dst = 3'd4; y_dst = 3'd4; local_dst = 3'd4;
    for (int c = 1; c <= 40; c++) begin
      cyc(1); #1;
      g = (c - 1) / 9;
      pos = (c - 1) % 9;
`ifdef SA_FIXED_PRIO_EN
      code = 3'd1;
`else
      code = 3'((g % 4) + 1);
`endif
      if (pos == 8) begin
        chk("t5_bubble", 8'(local_v), 8'd0);
      end else begin
        chk("t5_sw", 8'(local_sw), 8'(code));
        chk("t5_en", 8'(evec()), 8'(4'b0001 << (code - 3'd1)));
      end
    end

    // 6: asynchronous reset mid-grant (cycle 40 is inside X1's grant)
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 8'(vvec()), 8'h0);
    chk("t6_rst_en", 8'(evec()), 8'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1); #1;
    chk("t6_first_sw", 8'(local_sw), 8'd1);
    chk("t6_first_en", 8'(evec()), 8'b0001);
    x1_dst = '0; x2_dst = '0; y_dst = '0; local_dst = '0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
